// File: rtl/wooden_bits_pkg.sv
// wooden_bits_pkg: shared sizes, BCD digit type and WS2812 cycle-count helpers.
package wooden_bits_pkg;
    localparam int NUM_PIXELS     = 16;
    localparam int BITS_PER_PIXEL = 24;

    typedef logic [3:0] digit_t;

    // Rounds to nearest (or up, for the reset gap) and never returns less than one cycle.
    function automatic int ns_to_cycles(input longint clk_hz, input longint ns, input bit round_up);
        longint c;
        c = (clk_hz * ns + (round_up ? 64'd999_999_999 : 64'd500_000_000)) / 64'd1_000_000_000;
        return (c < 1) ? 1 : int'(c);
    endfunction

    function automatic int t0h_cycles(input int clk_hz);
        return ns_to_cycles(clk_hz, 400, 1'b0);
    endfunction

    function automatic int t0l_cycles(input int clk_hz);
        return ns_to_cycles(clk_hz, 850, 1'b0);
    endfunction

    function automatic int t1h_cycles(input int clk_hz);
        return ns_to_cycles(clk_hz, 800, 1'b0);
    endfunction

    function automatic int t1l_cycles(input int clk_hz);
        return ns_to_cycles(clk_hz, 450, 1'b0);
    endfunction

    function automatic int treset_cycles(input int clk_hz);
        return ns_to_cycles(clk_hz, 60_000, 1'b1);
    endfunction
endpackage

// File: rtl/wooden_bits_top_ws2812_driver.sv
// ws2812_driver: serialises 16 on/off pixels as 24-bit GRB words, MSB first, then a reset gap.
module ws2812_driver
    import wooden_bits_pkg::*;
#(
    parameter int          MAIN_CLK = 12_000_000,
    parameter logic [23:0] ON_GRB   = 24'h00_30_00
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [NUM_PIXELS-1:0] pixel_bits,
    output logic                  busy,
    output logic                  WS2812_DATA
);
    typedef enum logic [1:0] {IDLE, SEND_HIGH, SEND_LOW, LATCH} state_t;

    // Counters are loaded with length-1 and count down to zero.
    localparam logic [31:0] T0H  = 32'(t0h_cycles(MAIN_CLK) - 1);
    localparam logic [31:0] T0L  = 32'(t0l_cycles(MAIN_CLK) - 1);
    localparam logic [31:0] T1H  = 32'(t1h_cycles(MAIN_CLK) - 1);
    localparam logic [31:0] T1L  = 32'(t1l_cycles(MAIN_CLK) - 1);
    localparam logic [31:0] TRES = 32'(treset_cycles(MAIN_CLK) - 1);
    localparam logic [4:0]  LAST_SUB = 5'(BITS_PER_PIXEL - 1);
    localparam logic [3:0]  LAST_PIX = 4'(NUM_PIXELS - 1);

    state_t                state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [3:0]            pix_q, pix_d, npix;
    logic [4:0]            sub_q, sub_d, nsub;
    logic [NUM_PIXELS-1:0] bits_q, bits_d;
    logic                  data_q, data_d;
    logic                  cur_bit, nxt_bit, last_bit;

    always_comb begin
        last_bit = (pix_q == LAST_PIX) && (sub_q == LAST_SUB);
        nsub     = (sub_q == LAST_SUB) ? 5'd0 : sub_q + 5'd1;
        npix     = (sub_q == LAST_SUB) ? pix_q + 4'd1 : pix_q;
        cur_bit  = bits_q[pix_q] & ON_GRB[LAST_SUB - sub_q];
        nxt_bit  = bits_q[npix] & ON_GRB[LAST_SUB - nsub];
        state_d  = state_q;
        cnt_d    = cnt_q;
        pix_d    = pix_q;
        sub_d    = sub_q;
        bits_d   = bits_q;
        case (state_q)
            IDLE: if (start) begin
                bits_d  = pixel_bits;
                pix_d   = '0;
                sub_d   = '0;
                state_d = SEND_HIGH;
                cnt_d   = (pixel_bits[0] & ON_GRB[23]) ? T1H : T0H;
            end
            SEND_HIGH: if (cnt_q == 32'd0) begin
                state_d = SEND_LOW;
                cnt_d   = cur_bit ? T1L : T0L;
            end else cnt_d = cnt_q - 32'd1;
            SEND_LOW: if (cnt_q != 32'd0) cnt_d = cnt_q - 32'd1;
            else if (last_bit) begin
                state_d = LATCH;
                cnt_d   = TRES;
            end else begin
                pix_d   = npix;
                sub_d   = nsub;
                state_d = SEND_HIGH;
                cnt_d   = nxt_bit ? T1H : T0H;
            end
            LATCH: if (cnt_q == 32'd0) state_d = IDLE;
            else cnt_d = cnt_q - 32'd1;
            default: state_d = IDLE;
        endcase
        data_d = (state_d == SEND_HIGH);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pix_q   <= '0;
            sub_q   <= '0;
            bits_q  <= '0;
            data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            sub_q   <= sub_d;
            bits_q  <= bits_d;
            data_q  <= data_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign WS2812_DATA = data_q;
endmodule

// File: rtl/wooden_bits_top.sv
// wooden_bits_top: 24 h BCD clock from a 1 Hz tick with set button, status LEDs and a WS2812 display.
module wooden_bits_top
    import wooden_bits_pkg::*;
#(
    parameter int          MAIN_CLK = 12_000_000,
    parameter bit          EXT_TICK = 1'b0,
    parameter logic [23:0] ON_GRB   = 24'h00_30_00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLK_1HZ,
    input  logic       BTN,
    output logic [4:0] LED,
    output logic       WS2812_DATA
);
    localparam int            PW   = (MAIN_CLK > 1) ? $clog2(MAIN_CLK) : 1;
    localparam logic [PW-1:0] PMAX = PW'(MAIN_CLK - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          hz_s1_q, hz_s2_q, hz_prev_q, btn_s1_q, btn_s2_q;
    digit_t        dh1, dh0, dm1, dm0, ds1, ds0;
    digit_t        dh1_d, dh0_d, dm1_d, dm0_d, ds1_d, ds0_d;
    logic [4:0]    led_q, led_d;
    logic          tick, set_mode, min_inc, hr_inc, busy;

    always_comb begin
        presc_d  = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
        tick     = EXT_TICK ? (hz_s2_q & ~hz_prev_q) : (presc_q == PMAX);
        set_mode = ~btn_s2_q;
        {dh1_d, dh0_d, dm1_d, dm0_d, ds1_d, ds0_d} = {dh1, dh0, dm1, dm0, ds1, ds0};
        min_inc  = 1'b0;
        hr_inc   = 1'b0;
        // Set mode replaces the seconds step with a minute step and pins seconds at 00.
        if (tick) begin
            if (set_mode) begin
                ds1_d   = '0;
                ds0_d   = '0;
                min_inc = 1'b1;
            end else if (ds0 != 4'd9) ds0_d = ds0 + 4'd1;
            else begin
                ds0_d   = '0;
                ds1_d   = (ds1 == 4'd5) ? 4'd0 : ds1 + 4'd1;
                min_inc = (ds1 == 4'd5);
            end
        end
        if (min_inc) begin
            if (dm0 != 4'd9) dm0_d = dm0 + 4'd1;
            else begin
                dm0_d  = '0;
                dm1_d  = (dm1 == 4'd5) ? 4'd0 : dm1 + 4'd1;
                hr_inc = (dm1 == 4'd5);
            end
        end
        if (hr_inc) begin
            if (dh1 == 4'd2 && dh0 == 4'd3) begin
                dh1_d = '0;
                dh0_d = '0;
            end else if (dh0 == 4'd9) begin
                dh0_d = '0;
                dh1_d = dh1 + 4'd1;
            end else dh0_d = dh0 + 4'd1;
        end
        led_d = {ds0_d[0], dm0_d};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q   <= '0;
            hz_s1_q   <= 1'b0;
            hz_s2_q   <= 1'b0;
            hz_prev_q <= 1'b0;
            btn_s1_q  <= 1'b1;
            btn_s2_q  <= 1'b1;
            {dh1, dh0, dm1, dm0, ds1, ds0} <= '0;
            led_q     <= '0;
        end else begin
            presc_q   <= presc_d;
            hz_s1_q   <= CLK_1HZ;
            hz_s2_q   <= hz_s1_q;
            hz_prev_q <= hz_s2_q;
            btn_s1_q  <= BTN;
            btn_s2_q  <= btn_s1_q;
            {dh1, dh0, dm1, dm0, ds1, ds0} <= {dh1_d, dh0_d, dm1_d, dm0_d, ds1_d, ds0_d};
            led_q     <= led_d;
        end
    end

    assign LED = led_q;

    ws2812_driver #(.MAIN_CLK(MAIN_CLK), .ON_GRB(ON_GRB)) u_drv (
        .CLK        (CLK),
        .RST        (RST),
        .start      (~busy),
        .pixel_bits ({dm0, dm1, dh0, dh1}),
        .busy       (busy),
        .WS2812_DATA(WS2812_DATA)
    );
endmodule

// File: tb/tb_wooden_bits_top.sv
// tb_wooden_bits_top: directed checks of the BCD clock chain, set mode and one 12 MHz WS2812 frame.
module tb_wooden_bits_top;
    logic       clk = 1'b0;
    logic       rst, btn, hz, rst2, btn2, hz2;
    logic [4:0] led, led2;
    logic       ws, ws2;
    int         nerr = 0, nchk = 0;
    int         run, g, h, l, nbits, ones, bad_hi;
    logic       b;
    logic [23:0] pix_word [16];
    logic [15:0] lit;

    always #5 clk = ~clk;

    wooden_bits_top #(.MAIN_CLK(2), .EXT_TICK(1'b0)) dut (
        .CLK(clk), .RST(rst), .CLK_1HZ(hz), .BTN(btn), .LED(led), .WS2812_DATA(ws)
    );

    wooden_bits_top #(.MAIN_CLK(12_000_000), .EXT_TICK(1'b1)) dut2 (
        .CLK(clk), .RST(rst2), .CLK_1HZ(hz2), .BTN(btn2), .LED(led2), .WS2812_DATA(ws2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] tm1();
        return {dut.dh1, dut.dh0, dut.dm1, dut.dm0, dut.ds1, dut.ds0};
    endfunction

    // MAIN_CLK=2: one tick every two clocks.
    task automatic ticks(input int n);
        repeat (2 * n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; btn = 1'b1; hz = 1'b0;
        rst2 = 1'b1; btn2 = 1'b0; hz2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_time", 32'(tm1()), 32'h000000);
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_ws", 32'(ws), 32'h0);
        rst = 1'b0;
        ticks(5);
        chk("run5", 32'(tm1()), 32'h000005);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_time", 32'(tm1()), 32'h000000);
        chk("midrst_led", 32'(led), 32'h0);
        chk("midrst_ws", 32'(ws), 32'h0);
        rst = 1'b0;
        ticks(60);
        chk("t60", 32'(tm1()), 32'h000100);
        chk("t60_led", 32'(led), 32'h01);
        ticks(3540);
        chk("t3600", 32'(tm1()), 32'h010000);
        btn = 1'b0;
        ticks(1);
        chk("btn_sync_lag", 32'(tm1()), 32'h010001);
        ticks(1378);
        chk("set_to_2358", 32'(tm1()), 32'h235800);
        btn = 1'b1;
        ticks(60);
        chk("t235959", 32'(tm1()), 32'h235959);
        chk("hour23", 32'({dut.dh1, dut.dh0}), 32'h23);
        chk("t235959_led", 32'(led), 32'h19);
        ticks(1);
        chk("day_wrap", 32'(tm1()), 32'h000000);
        btn = 1'b0;
        ticks(181);
        chk("set180", 32'(tm1()), 32'h030000);
        btn = 1'b1;
        ticks(1);
        chk("release_lag", 32'(tm1()), 32'h030100);
        ticks(1);
        chk("release_sec", 32'(tm1()), 32'h030101);
        btn = 1'b0;
        ticks(419);
        chk("set_to_0959", 32'(tm1()), 32'h095900);
        chk("t0959_led", 32'(led), 32'h09);
        ticks(1);
        chk("set_0959_carry", 32'(tm1()), 32'h100000);

        // 12 MHz instance: advance to 12:34 with fast external ticks in set mode.
        rst2 = 1'b0;
        for (int i = 0; i < 754; i++) begin
            hz2 = 1'b1;
            repeat (3) @(negedge clk);
            hz2 = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("ext_1234", 32'({dut2.dh1, dut2.dh0, dut2.dm1, dut2.dm0, dut2.ds1, dut2.ds0}), 32'h123400);
        chk("ext_led", 32'(led2), 32'h04);
        run = 0; g = 0;
        while (run < 700 && g < 20000) begin
            @(negedge clk);
            run = ws2 ? 0 : run + 1;
            g++;
        end
        chk("gap_found", 32'(run >= 700), 32'h1);
        nbits = 0; ones = 0; bad_hi = 0;
        for (int i = 0; i < 384; i++) begin
            g = 0;
            while (!ws2 && g < 2000) begin @(negedge clk); g++; end
            h = 0;
            while (ws2 && h < 2000) begin @(negedge clk); h++; end
            if (g < 2000) nbits++;
            b = (h == 10);
            if (h != 10 && h != 5) bad_hi++;
            if (b) ones++;
            pix_word[i / 24][23 - (i % 24)] = b;
        end
        l = 0;
        while (!ws2 && l < 5000) begin @(negedge clk); l++; end
        for (int p = 0; p < 16; p++) lit[p] = (pix_word[p] != 24'h0);
        chk("frame_bits", 32'(nbits), 32'd384);
        chk("high_times", 32'(bad_hi), 32'd0);
        chk("one_bits", 32'(ones), 32'd10);
        chk("lit_mask", 32'(lit), 32'h4321);
        chk("pix0", 32'(pix_word[0]), 32'h003000);
        chk("pix4", 32'(pix_word[4]), 32'h000000);
        chk("pix5", 32'(pix_word[5]), 32'h003000);
        chk("reset_gap", 32'(l >= 720), 32'h1);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
